// File: rtl/pipe_reg_stage_hs.sv
// EXE/MEM handshaked pipeline register with flush and bubble-safe control output.
// Define PIPE_REG_SKID_EN to add a second (skid) entry so MEM back-pressure never drops in_ready early.
module pipe_reg_stage_hs #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3,
    parameter int RN_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_q2,
    input  logic [RN_W-1:0]   in_wrn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_datain,
    output logic [RN_W-1:0]   out_wrn,
    output logic [1:0]        occupancy
);

    localparam int ENT_W = CTRL_W + 2 * DATA_W + RN_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   main_q, main_d;
    logic [ENT_W-1:0]   inEntry;
    logic               accept;
    logic               deliver;
`ifdef PIPE_REG_SKID_EN
    logic [ENT_W-1:0]   skid_q, skid_d;
`endif

    assign inEntry   = {in_ctrl, in_alu, in_q2, in_wrn};
    assign out_valid = (state_q != EMPTY);

`ifdef PIPE_REG_SKID_EN
    // Ready comes only from registered state, so MEM's out_ready never reaches EXE combinationally.
    assign in_ready = !reset && !flush && (state_q != FULL);
`else
    assign in_ready = !reset && !flush && (!out_valid || out_ready);
`endif

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    assign out_ctrl   = out_valid ? main_q[ENT_W-1 -: CTRL_W] : '0;
    assign out_alu    = main_q[2*DATA_W+RN_W-1 -: DATA_W];
    assign out_datain = main_q[DATA_W+RN_W-1 -: DATA_W];
    assign out_wrn    = main_q[RN_W-1:0];

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Next-state logic; flush drops every held entry but leaves data registers untouched.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_REG_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = inEntry;
                    end
                end
                ONE: begin
`ifdef PIPE_REG_SKID_EN
                    if (accept && deliver) begin
                        main_d = inEntry;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = inEntry;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
`else
                    if (accept) begin
                        main_d = inEntry;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
`endif
                end
                FULL: begin
`ifdef PIPE_REG_SKID_EN
                    if (deliver) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
`else
                    state_d = EMPTY;
`endif
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
`ifdef PIPE_REG_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_REG_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

endmodule
